// File: rtl/fft_peak_scheduler_pkg.sv
// Shared types, spectrum word field layout and magnitude helper for the
// FFT peak scheduler.
package fft_peak_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Spectrum word layout: {re, im}, both two's complement.
  localparam int RE_MSB = 35;
  localparam int RE_LSB = 18;
  localparam int IM_MSB = 17;
  localparam int IM_LSB = 0;
  localparam int COMP_W = RE_MSB - RE_LSB + 1;

  // |re| + |im| of two 18-bit components never exceeds 2^18, so 19 bits hold it.
  localparam int MAG_W = 19;

  // Absolute value widened by one bit so that |-2^17| = 2^17 is exact.
  function automatic logic [MAG_W-1:0] abs_comp(input logic signed [COMP_W-1:0] v);
    logic signed [MAG_W-1:0] wide;
    wide = MAG_W'(v);
    return v[COMP_W-1] ? MAG_W'(-wide) : MAG_W'(wide);
  endfunction

endpackage

// File: rtl/fft_peak_scheduler_if.sv
// Bus bundle for the peak scheduler: frame trigger, spectrum RAM read port,
// external read port and the per-frame peak report.
interface fft_peak_scheduler_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36
);
  import fft_peak_scheduler_pkg::*;

  logic              fft_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_rvalid;
  logic [ADDR_W-1:0] ext_addr;
  logic              ext_re;
  logic [DATA_W-1:0] ext_data;
  logic              ext_valid;
  logic              busy;
  logic              peak_valid;
  logic [ADDR_W-1:0] peak_bin;
  logic [MAG_W-1:0]  peak_mag;
  logic              no_signal;

  // Scheduler side.
  modport master (
    input  fft_done, ram_rdata, ram_rvalid, ext_addr, ext_re,
    output ram_addr, ram_re, ext_data, ext_valid, busy,
           peak_valid, peak_bin, peak_mag, no_signal
  );

  // Environment side: RAM, external requester and note-decision logic.
  modport slave (
    output fft_done, ram_rdata, ram_rvalid, ext_addr, ext_re,
    input  ram_addr, ram_re, ext_data, ext_valid, busy,
           peak_valid, peak_bin, peak_mag, no_signal
  );

endinterface

// File: rtl/fft_peak_scheduler_mag_approx.sv
// One-stage registered |re| + |im| magnitude approximation; the valid flag
// and bin index ride along with the result.
module fft_mag_approx
  import fft_peak_scheduler_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_bin,
  output logic              out_valid,
  output logic [MAG_W-1:0]  out_mag,
  output logic [ADDR_W-1:0] out_bin
);

  logic signed [COMP_W-1:0] re_val;
  logic signed [COMP_W-1:0] im_val;
  logic [MAG_W-1:0]         mag_next;
  logic                     valid_reg;
  logic [MAG_W-1:0]         mag_reg;
  logic [ADDR_W-1:0]        bin_reg;

  assign re_val   = in_data[RE_MSB:RE_LSB];
  assign im_val   = in_data[IM_MSB:IM_LSB];
  assign mag_next = abs_comp(re_val) + abs_comp(im_val);

  // Register magnitude and bin only when a scan return is present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      mag_reg   <= '0;
      bin_reg   <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        mag_reg <= mag_next;
        bin_reg <= in_bin;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_mag   = mag_reg;
  assign out_bin   = bin_reg;

endmodule

// File: rtl/fft_peak_scheduler.sv
// Walks the spectrum RAM once per frame, shares the read port with an
// external requester (external always wins), and reports the strongest bin.
module fft_peak_scheduler
  import fft_peak_scheduler_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 36,
  parameter int FIRST_BIN = 1,
  parameter int LAST_BIN  = 511,
  parameter int RD_LAT    = 2,
  parameter int MIN_MAG   = 64
) (
  input logic                  clk,
  input logic                  reset,
  fft_peak_scheduler_if.master bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] scan_addr_reg, scan_addr_next;
  logic              pending_reg, pending_next;
  logic              start_scan;
  logic              load_peak;
  logic              scan_issue;

  // Return pipe: valid, tag (1 = external) and bin index per issued read.
  logic [RD_LAT-1:0] pv_reg;
  logic [RD_LAT-1:0] pt_reg;
  logic [ADDR_W-1:0] pb_reg [RD_LAT];
  logic [RD_LAT-1:0] scan_entry;
  logic              scan_in_pipe;
  logic              pipe_valid_out;
  logic              pipe_tag_out;
  logic              ext_valid_w;
  logic              scan_ret;

  logic              mag_valid;
  logic [MAG_W-1:0]  mag_val;
  logic [ADDR_W-1:0] mag_bin;

  logic [MAG_W-1:0]  max_mag_reg, max_mag_next;
  logic [ADDR_W-1:0] max_bin_reg, max_bin_next;

  logic [ADDR_W-1:0] peak_bin_reg;
  logic [MAG_W-1:0]  peak_mag_reg;
  logic              no_signal_reg;

  // ---------------- Read port arbitration ----------------
  assign scan_issue   = (state_reg == SCAN) && !bus.ext_re;
  assign bus.ram_re   = bus.ext_re || (state_reg == SCAN);
  assign bus.ram_addr = bus.ext_re ? bus.ext_addr : scan_addr_reg;

  // ---------------- Return routing ----------------
  // Shift one entry per cycle so the tag lines up with ram_rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_reg <= '0;
      pt_reg <= '0;
      for (int i = 0; i < RD_LAT; i++) pb_reg[i] <= '0;
    end else begin
      pv_reg[0] <= bus.ram_re;
      pt_reg[0] <= bus.ext_re;
      pb_reg[0] <= scan_addr_reg;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_reg[i] <= pv_reg[i-1];
        pt_reg[i] <= pt_reg[i-1];
        pb_reg[i] <= pb_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_scan_entry
      assign scan_entry[gi] = pv_reg[gi] & ~pt_reg[gi];
    end
  endgenerate

  assign scan_in_pipe   = |scan_entry;
  assign pipe_valid_out = pv_reg[RD_LAT-1];
  assign pipe_tag_out   = pt_reg[RD_LAT-1];

  // Returns are qualified by the pipe so reads launched before a reset are ignored.
  assign ext_valid_w   = bus.ram_rvalid & pipe_valid_out & pipe_tag_out;
  assign scan_ret      = bus.ram_rvalid & pipe_valid_out & ~pipe_tag_out;
  assign bus.ext_valid = ext_valid_w;
  assign bus.ext_data  = ext_valid_w ? bus.ram_rdata : '0;

  fft_mag_approx #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mag (
    .clk      (clk),
    .reset    (reset),
    .in_valid (scan_ret),
    .in_data  (bus.ram_rdata),
    .in_bin   (pb_reg[RD_LAT-1]),
    .out_valid(mag_valid),
    .out_mag  (mag_val),
    .out_bin  (mag_bin)
  );

  // ---------------- Max tracking ----------------
  // Strict compare so that on a tie the earlier (lower) bin is kept.
  always_comb begin
    max_mag_next = max_mag_reg;
    max_bin_next = max_bin_reg;
    if (start_scan) begin
      max_mag_next = '0;
      max_bin_next = ADDR_W'(FIRST_BIN);
    end else if (mag_valid && (mag_val > max_mag_reg)) begin
      max_mag_next = mag_val;
      max_bin_next = mag_bin;
    end
  end

  // Running maximum for the frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_mag_reg <= '0;
      max_bin_reg <= '0;
    end else begin
      max_mag_reg <= max_mag_next;
      max_bin_reg <= max_bin_next;
    end
  end

  // ---------------- Control FSM ----------------
  // Next state, scan address and pending-frame bookkeeping.
  always_comb begin
    state_next     = state_reg;
    scan_addr_next = scan_addr_reg;
    pending_next   = pending_reg;
    start_scan     = 1'b0;
    load_peak      = 1'b0;

    if (bus.fft_done && (state_reg != IDLE)) pending_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (bus.fft_done || pending_reg) begin
          state_next     = SCAN;
          scan_addr_next = ADDR_W'(FIRST_BIN);
          pending_next   = 1'b0;
          start_scan     = 1'b1;
        end
      end
      SCAN: begin
        if (scan_issue) begin
          if (scan_addr_reg == ADDR_W'(LAST_BIN)) state_next = DRAIN;
          else scan_addr_next = scan_addr_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Once no scan read is outstanding, the last magnitude is folded into
        // max_*_next on this same edge, so the result can be captured now.
        if (!scan_in_pipe) begin
          state_next = DONE;
          load_peak  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, scan counter and pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      scan_addr_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      scan_addr_reg <= scan_addr_next;
      pending_reg   <= pending_next;
    end
  end

  // Peak report, held between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_bin_reg  <= '0;
      peak_mag_reg  <= '0;
      no_signal_reg <= 1'b0;
    end else if (load_peak) begin
      peak_bin_reg  <= max_bin_next;
      peak_mag_reg  <= max_mag_next;
      no_signal_reg <= (max_mag_next < MAG_W'(MIN_MAG));
    end
  end

  assign bus.busy       = (state_reg == SCAN) || (state_reg == DRAIN);
  assign bus.peak_valid = (state_reg == DONE);
  assign bus.peak_bin   = peak_bin_reg;
  assign bus.peak_mag   = peak_mag_reg;
  assign bus.no_signal  = no_signal_reg;

endmodule
